// File: rtl/config_pkg.sv
// Shared DDR widths used by blocks that talk to the memory port.
package config_pkg;
  typedef logic [31:0] ddr_address_t;
  typedef logic [31:0] ddr_data_t;
endpackage

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR port among NumPorts requesters,
// one pending slot per port and at most one DDR transaction in flight.
module ddr_port_arbiter
  import config_pkg::*;
#(
  parameter int unsigned NumPorts = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  ddr_address_t [NumPorts-1:0] req_address_i,
  input  logic [NumPorts-1:0]         req_w_en_i,
  input  ddr_data_t [NumPorts-1:0]    req_w_data_i,
  input  logic [NumPorts-1:0]         req_r_en_i,
  output logic [NumPorts-1:0]         rsp_w_done_o,
  output logic [NumPorts-1:0]         rsp_r_valid_o,
  output ddr_data_t                   rsp_r_data_o,
  output logic [NumPorts-1:0]         overrun_o,
  output ddr_address_t                ddr_address_o,
  output logic                        ddr_w_en_o,
  output ddr_data_t                   ddr_w_data_o,
  output logic                        ddr_r_en_o,
  input  logic                        ddr_w_done_i,
  input  ddr_data_t                   ddr_r_data_i,
  input  logic                        ddr_r_valid_i
);

  localparam int unsigned PortW = $clog2(NumPorts);
  typedef logic [PortW-1:0] port_idx_t;

  typedef enum logic [1:0] {StIdle, StWaitRead, StWaitWrite} state_e;

  state_e                      state_q, state_d;
  logic [NumPorts-1:0]         slot_valid_q, slot_valid_d;
  logic [NumPorts-1:0]         slot_write_q, slot_write_d;
  ddr_address_t [NumPorts-1:0] slot_addr_q, slot_addr_d;
  ddr_data_t [NumPorts-1:0]    slot_data_q, slot_data_d;
  logic [NumPorts-1:0]         overrun_q, overrun_d;
  port_idx_t                   last_grant_q, last_grant_d;
  port_idx_t                   active_q, active_d;

  logic      grant_valid;
  port_idx_t grant_idx;

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin
    int unsigned cand;
    port_idx_t   cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (state_q == StIdle) begin
      for (int unsigned k = 1; k <= NumPorts; k++) begin
        cand     = (32'(last_grant_q) + k) % NumPorts;
        cand_idx = port_idx_t'(cand);
        if (!grant_valid && slot_valid_q[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // A new request may reuse a slot that is being granted this cycle.
  always_comb begin
    logic req_any;
    logic clr;
    req_any      = 1'b0;
    clr          = 1'b0;
    slot_valid_d = slot_valid_q;
    slot_write_d = slot_write_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    overrun_d    = overrun_q;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      req_any = req_w_en_i[p] | req_r_en_i[p];
      clr     = grant_valid && (grant_idx == port_idx_t'(p));
      if (req_any && (!slot_valid_q[p] || clr)) begin
        slot_valid_d[p] = 1'b1;
        slot_write_d[p] = req_w_en_i[p];
        slot_addr_d[p]  = req_address_i[p];
        slot_data_d[p]  = req_w_en_i[p] ? req_w_data_i[p] : '0;
      end else if (req_any) begin
        overrun_d[p] = 1'b1;
      end else if (clr) begin
        slot_valid_d[p] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    last_grant_d  = last_grant_q;
    ddr_address_o = '0;
    ddr_w_data_o  = '0;
    ddr_w_en_o    = 1'b0;
    ddr_r_en_o    = 1'b0;
    rsp_w_done_o  = '0;
    rsp_r_valid_o = '0;
    rsp_r_data_o  = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          ddr_address_o = slot_addr_q[grant_idx];
          ddr_w_data_o  = slot_data_q[grant_idx];
          ddr_w_en_o    = slot_write_q[grant_idx];
          ddr_r_en_o    = ~slot_write_q[grant_idx];
          active_d      = grant_idx;
          last_grant_d  = grant_idx;
          state_d       = slot_write_q[grant_idx] ? StWaitWrite : StWaitRead;
        end
      end
      StWaitRead: begin
        if (ddr_r_valid_i) begin
          rsp_r_valid_o[active_q] = 1'b1;
          rsp_r_data_o            = ddr_r_data_i;
          state_d                 = StIdle;
        end
      end
      StWaitWrite: begin
        if (ddr_w_done_i) begin
          rsp_w_done_o[active_q] = 1'b1;
          state_d                = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign overrun_o = overrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      slot_valid_q <= '0;
      slot_write_q <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      overrun_q    <= '0;
      last_grant_q <= port_idx_t'(NumPorts - 1);
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_write_q <= slot_write_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      active_q     <= active_d;
    end
  end

endmodule
